vga_timing_ctrl: RTL

Top-level VGA timing sequencer for the Pong display path. It steps the horizontal and vertical position counters through active, front-porch, sync and back-porch phases. It drives hsync/vsync, the active-video flag and pixel coordinates. It also emits line, frame and vblank strobes that the game logic and renderer use to schedule per-frame updates.

---
 rtl/vga_pkg.sv | 38 +++
 rtl/vga_axis_seq.sv | 74 +++++++
 rtl/vga_timing_ctrl.sv | 141 ++++++++++++++
 3 files changed

// File: rtl/vga_pkg.sv
// Shared phase type, default 640x480@60 timing constants and total-length helpers
// for the VGA timing sequencer.
package vga_pkg;

  typedef enum logic [1:0] {
    ACTIVE = 2'd0,
    FP     = 2'd1,
    SYNC   = 2'd2,
    BP     = 2'd3
  } phase_t;

  localparam int unsigned CNT_W = 10;

  localparam int unsigned DEF_H_ACTIVE = 640;
  localparam int unsigned DEF_H_FP     = 16;
  localparam int unsigned DEF_H_SYNC   = 96;
  localparam int unsigned DEF_H_BP     = 48;
  localparam int unsigned DEF_V_ACTIVE = 480;
  localparam int unsigned DEF_V_FP     = 10;
  localparam int unsigned DEF_V_SYNC   = 2;
  localparam int unsigned DEF_V_BP     = 33;

  function automatic int unsigned axis_total(input int unsigned a, input int unsigned f,
                                             input int unsigned s, input int unsigned b);
    return a + f + s + b;
  endfunction

  function automatic int unsigned h_total(input int unsigned a, input int unsigned f,
                                          input int unsigned s, input int unsigned b);
    return axis_total(a, f, s, b);
  endfunction

  function automatic int unsigned v_total(input int unsigned a, input int unsigned f,
                                          input int unsigned s, input int unsigned b);
    return axis_total(a, f, s, b);
  endfunction

endpackage

// File: rtl/vga_axis_seq.sv
// One timing axis: position counter plus ACTIVE/FP/SYNC/BP phase FSM, stepping on advance.
// Used once for the horizontal axis and once, chained on the horizontal wrap, for vertical.
module vga_axis_seq
  import vga_pkg::*;
#(
  parameter int unsigned ACT_LEN  = DEF_H_ACTIVE,
  parameter int unsigned FP_LEN   = DEF_H_FP,
  parameter int unsigned SYNC_LEN = DEF_H_SYNC,
  parameter int unsigned BP_LEN   = DEF_H_BP
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             advance,
  output logic [CNT_W-1:0] count,
  output phase_t           phase,
  output phase_t           phase_nxt,
  output logic             wrap
);

  localparam logic [CNT_W-1:0] LAST_ACT  = CNT_W'(ACT_LEN - 1);
  localparam logic [CNT_W-1:0] LAST_FP   = CNT_W'(ACT_LEN + FP_LEN - 1);
  localparam logic [CNT_W-1:0] LAST_SYNC = CNT_W'(ACT_LEN + FP_LEN + SYNC_LEN - 1);
  localparam logic [CNT_W-1:0] LAST_BP   = CNT_W'(axis_total(ACT_LEN, FP_LEN, SYNC_LEN, BP_LEN) - 1);
  localparam logic [CNT_W-1:0] CNT_ONE   = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] CNT_ZERO  = {CNT_W{1'b0}};

  logic [CNT_W-1:0] count_r;
  logic [CNT_W-1:0] count_nxt_s;
  phase_t           phase_r;
  phase_t           phase_nxt_s;
  logic             wrap_s;

  // next count and phase; phase boundaries are the last count of each phase
  always_comb begin
    count_nxt_s = count_r;
    phase_nxt_s = phase_r;
    wrap_s      = 1'b0;
    if (advance) begin
      if (count_r == LAST_BP) begin
        count_nxt_s = CNT_ZERO;
        wrap_s      = 1'b1;
      end else begin
        count_nxt_s = count_r + CNT_ONE;
      end
      case (phase_r)
        ACTIVE:  phase_nxt_s = (count_r == LAST_ACT)  ? FP     : ACTIVE;
        FP:      phase_nxt_s = (count_r == LAST_FP)   ? SYNC   : FP;
        SYNC:    phase_nxt_s = (count_r == LAST_SYNC) ? BP     : SYNC;
        BP:      phase_nxt_s = (count_r == LAST_BP)   ? ACTIVE : BP;
        default: phase_nxt_s = ACTIVE;
      endcase
    end else begin
      count_nxt_s = count_r;
      phase_nxt_s = phase_r;
    end
  end

  // position and phase state
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count_r <= CNT_ZERO;
      phase_r <= ACTIVE;
    end else begin
      count_r <= count_nxt_s;
      phase_r <= phase_nxt_s;
    end
  end

  assign count     = count_r;
  assign phase     = phase_r;
  assign phase_nxt = phase_nxt_s;
  assign wrap      = wrap_s;

endmodule

// File: rtl/vga_timing_ctrl.sv
// VGA timing sequencer: sync, active-video, coordinates and line/frame/vblank strobes.
// Define VGA_PIXDIV_EN to derive pix_tick as clk/2 (50 MHz clk, 25 MHz pixel rate).
module vga_timing_ctrl
  import vga_pkg::*;
#(
  parameter int unsigned H_ACTIVE = DEF_H_ACTIVE,
  parameter int unsigned H_FP     = DEF_H_FP,
  parameter int unsigned H_SYNC   = DEF_H_SYNC,
  parameter int unsigned H_BP     = DEF_H_BP,
  parameter int unsigned V_ACTIVE = DEF_V_ACTIVE,
  parameter int unsigned V_FP     = DEF_V_FP,
  parameter int unsigned V_SYNC   = DEF_V_SYNC,
  parameter int unsigned V_BP     = DEF_V_BP,
  parameter logic        SYNC_POL = 1'b0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enable,
  output logic             pix_tick,
  output logic             hsync,
  output logic             vsync,
  output logic             video_on,
  output logic [CNT_W-1:0] x,
  output logic [CNT_W-1:0] y,
  output logic             line_start,
  output logic             frame_start,
  output logic             vblank_start
);

  logic             pix_tick_r;
  logic             advance_s;
  logic [CNT_W-1:0] h_count_s;
  logic [CNT_W-1:0] v_count_s;
  phase_t           h_phase_s;
  phase_t           h_phase_nxt_s;
  phase_t           v_phase_s;
  phase_t           v_phase_nxt_s;
  logic             h_wrap_s;
  logic             v_wrap_s;
  logic             hsync_r;
  logic             vsync_r;
  logic             video_on_r;
  logic             line_start_r;
  logic             frame_start_r;
  logic             vblank_start_r;

`ifdef VGA_PIXDIV_EN
  // divide-by-two pixel tick; cleared by reset so the first tick is one clk late
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pix_tick_r <= 1'b0;
    end else begin
      pix_tick_r <= ~pix_tick_r;
    end
  end
`else
  // full-rate pixel tick: every clk is a pixel
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pix_tick_r <= 1'b1;
    end else begin
      pix_tick_r <= 1'b1;
    end
  end
`endif

  assign advance_s = enable & pix_tick_r;

  vga_axis_seq #(
    .ACT_LEN  (H_ACTIVE),
    .FP_LEN   (H_FP),
    .SYNC_LEN (H_SYNC),
    .BP_LEN   (H_BP)
  ) u_h_seq (
    .clk       (clk),
    .reset     (reset),
    .advance   (advance_s),
    .count     (h_count_s),
    .phase     (h_phase_s),
    .phase_nxt (h_phase_nxt_s),
    .wrap      (h_wrap_s)
  );

  // vertical axis steps once per completed line
  vga_axis_seq #(
    .ACT_LEN  (V_ACTIVE),
    .FP_LEN   (V_FP),
    .SYNC_LEN (V_SYNC),
    .BP_LEN   (V_BP)
  ) u_v_seq (
    .clk       (clk),
    .reset     (reset),
    .advance   (h_wrap_s),
    .count     (v_count_s),
    .phase     (v_phase_s),
    .phase_nxt (v_phase_nxt_s),
    .wrap      (v_wrap_s)
  );

  // sync/video levels follow the next phase so they land with the counters; strobes last one clk
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hsync_r        <= ~SYNC_POL;
      vsync_r        <= ~SYNC_POL;
      video_on_r     <= 1'b0;
      line_start_r   <= 1'b0;
      frame_start_r  <= 1'b0;
      vblank_start_r <= 1'b0;
    end else begin
      line_start_r   <= h_wrap_s;
      frame_start_r  <= h_wrap_s & v_wrap_s;
      vblank_start_r <= h_wrap_s & (v_phase_s == ACTIVE) & (v_phase_nxt_s == FP);
      if (h_phase_nxt_s != h_phase_s) begin
        hsync_r <= (h_phase_nxt_s == SYNC) ? SYNC_POL : ~SYNC_POL;
      end else begin
        hsync_r <= hsync_r;
      end
      if (v_phase_nxt_s != v_phase_s) begin
        vsync_r <= (v_phase_nxt_s == SYNC) ? SYNC_POL : ~SYNC_POL;
      end else begin
        vsync_r <= vsync_r;
      end
      if (advance_s) begin
        video_on_r <= (h_phase_nxt_s == ACTIVE) & (v_phase_nxt_s == ACTIVE);
      end else begin
        video_on_r <= video_on_r;
      end
    end
  end

  assign pix_tick     = pix_tick_r;
  assign hsync        = hsync_r;
  assign vsync        = vsync_r;
  assign video_on     = video_on_r;
  assign x            = h_count_s;
  assign y            = v_count_s;
  assign line_start   = line_start_r;
  assign frame_start  = frame_start_r;
  assign vblank_start = vblank_start_r;

endmodule
